// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring sequential divider with start/busy/done handshake
// Optional macro DIV_EARLY_EXIT_EN: finish immediately when |divisor| > |dividend|.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH+1:0] ONE_EXT  = (WIDTH + 2)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             not_borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;

  // Shifted partial remainder needs one extra bit; the top bit of the sum is the not-borrow.
  assign rem_sh     = {rem_q, dvd_q[WIDTH-1]};
  assign trial      = {1'b0, rem_sh} + {2'b01, ~dvs_q} + ONE_EXT;
  assign not_borrow = trial[WIDTH+1];
  assign rem_d      = not_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_d      = {dvd_q[WIDTH-2:0], not_borrow};
  assign quo_fix    = neg_quo_q ? (~quo_d + ONE) : quo_d;
  assign rem_fix    = neg_rem_q ? (~rem_d + ONE) : rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            dvd_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            rem_q     <= '0;
            count_q   <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b1;
            if (divisor == '0) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end
`ifdef DIV_EARLY_EXIT_EN
            else if (dvs_mag > dvd_mag) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              quotient_q  <= '0;
              remainder_q <= dividend;
            end
`endif
            else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q   <= rem_d;
          dvd_q   <= quo_d;
          count_q <= count_q + CNT_ONE;
          if (count_q == LAST_CNT) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            quotient_q  <= quo_fix;
            remainder_q <= rem_fix;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          count_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
